pulse_gen: RTL and testbench
============================

PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 Parameter CNT_W, default 32, width of the period, width and phase counters.
REQ-002 Parameter BURST_W, default 16, width of the burst-length counter.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low; it is the only reset.
REQ-005 ena  input  1  run enable; 0->1 edge starts generation, level 0 aborts.
REQ-006 cfg_load  input  1  one-cycle strobe that captures period_in, width_in and burst_in.
REQ-007 period_in  input  CNT_W  requested period in clk cycles.
REQ-008 width_in  input  CNT_W  requested high time in clk cycles.
REQ-009 burst_in  input  BURST_W  number of periods to emit; 0 means continuous.
REQ-010 pulse  output  1  generated pulse, driven directly from a register.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  one-cycle strobe when a finite burst completes.
REQ-013 period_cnt  output  BURST_W  periods completed in the current run, saturating.

Function
REQ-014 The state machine SHALL have two states: IDLE and RUN.
REQ-015 cfg_load SHALL write the pending registers; in IDLE the active registers SHALL copy pending on the same edge.
REQ-016 In RUN, pending SHALL transfer to active only at a period boundary, so no period is ever mixed.
REQ-017 IDLE->RUN SHALL occur on the edge where ena=1 and the registered ena_r=0, with active period != 0.
REQ-018 On the start edge: ph<=1, pulse<=(width_act!=0), period_cnt<=0, busy<=1; the first pulse rise is one cycle after ena rises.
REQ-019 In RUN, each edge with ph!=period_act: ph<=ph+1 and pulse<=(ph<width_act).
REQ-020 Each edge with ph==period_act is a boundary: ph<=1, pulse<=(width_act!=0), period_cnt increments and saturates at all-ones.
REQ-021 The result SHALL be pulse high for exactly width_act cycles out of every period_act cycles.
REQ-022 width_act=0 SHALL hold pulse low; width_act>=period_act SHALL hold pulse constantly high. Neither case is an error.
REQ-023 period_act=0 SHALL block the start; the block stays in IDLE with pulse=0.
REQ-024 When burst_act!=0, the boundary that brings period_cnt to burst_act SHALL go to IDLE with pulse<=0, busy<=0 and done<=1 for one cycle.
REQ-025 ena=0 in RUN SHALL abort on the next edge: IDLE, pulse<=0, busy<=0, done not asserted, period_cnt held.
REQ-026 cfg_load on the same edge as a boundary SHALL apply the newly loaded values to the new period.
REQ-027 A start and a cfg_load on the same edge SHALL use the newly loaded values.
REQ-028 All counter compares SHALL be unsigned at CNT_W bits; ph SHALL never wrap, since it resets at period_act.

Reset
REQ-029 When rst=0, the block SHALL go to IDLE and clear pulse, busy, done, period_cnt, ph, ena_r, and the pending and active registers.
REQ-030 Reset asserted mid-RUN SHALL force pulse low asynchronously, with no done strobe.
REQ-031 After reset release, a new ena rising edge SHALL be required before generation starts.

Structure
REQ-032 State encoding and the default CNT_W/BURST_W constants SHALL live in the shared sig_acq package.
REQ-033 One sub-module, pulse_gen_timer, SHALL contain the ph counter, the boundary detect and the pulse compare. The FSM, config registers and burst counter SHALL stay in the top.

Verification
REQ-034 Load period=10, width=3, burst=0, raise ena: pulse is high 3 cycles and low 7, repeating; a loopback pulse_measure reports period=10 and width=3.
REQ-035 Load period=5, width=2, burst=4: exactly 4 pulses; done is high for one cycle at the 4th boundary; busy drops; period_cnt=4.
REQ-036 Load width=0, then width=12 with period=8: pulse is constant 0, then constant 1 while running.
REQ-037 Run period=10, width=3, then cfg_load period=6, width=1 mid-period: the current period stays 10/3 and the next is 6/1.
REQ-038 Drop ena at ph=2 of a period: pulse=0 on the next edge; done stays 0; a fresh start gives its rise one cycle after ena.
REQ-039 Assert rst during a high phase: pulse=0 immediately; with period=0 loaded, an ena rise leaves busy=0.

Source files
------------

// File: rtl/sig_acq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sig_acq_pkg
//  Brief    : Shared types and default widths for the signal-acquisition blocks
//  Revision : 1.0  initial release
// ============================================================================
package sig_acq_pkg;

  localparam int unsigned CNT_W_DEF   = 32;
  localparam int unsigned BURST_W_DEF = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pg_state_e;

endpackage
`default_nettype wire

// File: rtl/pulse_gen_timer.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_gen_timer
//  Brief    : Phase counter, period-boundary detect and pulse compare
//  Revision : 1.0  initial release
// ============================================================================
module pulse_gen_timer
  import sig_acq_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,         // asynchronous, active-low
  input  logic             run_i,       // controller is in RUN
  input  logic             start_i,     // start edge: begin at phase 1
  input  logic             clear_i,     // abort / burst end: drop pulse
  input  logic [CNT_W-1:0] period_act_i,
  input  logic [CNT_W-1:0] width_act_i,
  input  logic [CNT_W-1:0] width_new_i, // width that applies to a new period
  output logic             boundary_o,
  output logic             pulse_o
);

  logic [CNT_W-1:0] ph_q;
  logic             pulse_q;

  // Phase 1..period_act; the last phase is the boundary, so ph never wraps.
  assign boundary_o = run_i && (ph_q == period_act_i);
  assign pulse_o    = pulse_q;

  // Advance the phase and compute the pulse level for the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph_q    <= '0;
      pulse_q <= 1'b0;
    end else if (clear_i) begin
      ph_q    <= '0;
      pulse_q <= 1'b0;
    end else if (start_i || boundary_o) begin
      ph_q    <= CNT_W'(1);
      pulse_q <= (width_new_i != '0);
    end else if (run_i) begin
      ph_q    <= ph_q + CNT_W'(1);
      pulse_q <= (ph_q < width_act_i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_gen
//  Brief    : Programmable periodic / burst pulse generator with glitch-free
//             reconfiguration at period boundaries
//  Revision : 1.0  initial release
// ============================================================================
module pulse_gen
  import sig_acq_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               rst,        // asynchronous, active-low
  input  logic               ena,
  input  logic               cfg_load,
  input  logic [CNT_W-1:0]   period_in,
  input  logic [CNT_W-1:0]   width_in,
  input  logic [BURST_W-1:0] burst_in,
  output logic               pulse,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] period_cnt
);

  pg_state_e          state_q;
  logic               ena_q;
  logic               busy_q;
  logic               done_q;
  logic [BURST_W-1:0] cnt_q;

  logic [CNT_W-1:0]   per_pend_q, wid_pend_q;
  logic [BURST_W-1:0] bur_pend_q;
  logic [CNT_W-1:0]   per_act_q,  wid_act_q;
  logic [BURST_W-1:0] bur_act_q;

  // Values that would become active on this edge: a same-edge cfg_load wins
  // over the pending set, so a start or boundary uses freshly loaded values.
  logic [CNT_W-1:0]   per_d, wid_d;
  logic [BURST_W-1:0] bur_d;
  logic [BURST_W-1:0] cnt_d;
  logic               start, abort, finish, clear, boundary;

  assign per_d  = cfg_load ? period_in : per_pend_q;
  assign wid_d  = cfg_load ? width_in  : wid_pend_q;
  assign bur_d  = cfg_load ? burst_in  : bur_pend_q;

  // Saturating completed-period count.
  assign cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + BURST_W'(1);

  assign start  = (state_q == ST_IDLE) && ena && !ena_q && (per_d != '0);
  assign abort  = (state_q == ST_RUN) && !ena;
  assign finish = (state_q == ST_RUN) && ena && boundary &&
                  (bur_act_q != '0) && (cnt_d == bur_act_q);
  assign clear  = abort || finish;

  assign busy       = busy_q;
  assign done       = done_q;
  assign period_cnt = cnt_q;

  pulse_gen_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .run_i        (state_q == ST_RUN),
    .start_i      (start),
    .clear_i      (clear),
    .period_act_i (per_act_q),
    .width_act_i  (wid_act_q),
    .width_new_i  (wid_d),
    .boundary_o   (boundary),
    .pulse_o      (pulse)
  );

  // Control FSM, configuration registers and burst accounting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ena_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      per_pend_q <= '0;
      wid_pend_q <= '0;
      bur_pend_q <= '0;
      per_act_q  <= '0;
      wid_act_q  <= '0;
      bur_act_q  <= '0;
    end else begin
      ena_q  <= ena;
      done_q <= 1'b0;

      if (cfg_load) begin
        per_pend_q <= period_in;
        wid_pend_q <= width_in;
        bur_pend_q <= burst_in;
      end

      case (state_q)
        ST_IDLE: begin
          // Nothing is running, so the active set tracks pending directly.
          per_act_q <= per_d;
          wid_act_q <= wid_d;
          bur_act_q <= bur_d;
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end

        ST_RUN: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (boundary) begin
            // Only swap configuration between periods.
            cnt_q     <= cnt_d;
            per_act_q <= per_d;
            wid_act_q <= wid_d;
            bur_act_q <= bur_d;
            if (finish) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pulse_gen
//  Brief    : Directed self-checking bench for pulse_gen
//  Revision : 1.0  initial release
// ============================================================================
module tb_pulse_gen;

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned BURST_W = 16;

  logic               clk;
  logic               rst;
  logic               ena;
  logic               cfg_load;
  logic [CNT_W-1:0]   period_in;
  logic [CNT_W-1:0]   width_in;
  logic [BURST_W-1:0] burst_in;
  logic               pulse;
  logic               busy;
  logic               done;
  logic [BURST_W-1:0] period_cnt;

  int n_checks;
  int n_pass;
  logic [63:0] vec;

  pulse_gen #(
    .CNT_W   (CNT_W),
    .BURST_W (BURST_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .cfg_load   (cfg_load),
    .period_in  (period_in),
    .width_in   (width_in),
    .burst_in   (burst_in),
    .pulse      (pulse),
    .busy       (busy),
    .done       (done),
    .period_cnt (period_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int p, input int w, input int b);
    period_in = CNT_W'(p);
    width_in  = CNT_W'(w);
    burst_in  = BURST_W'(b);
    cfg_load  = 1'b1;
    tick();
    cfg_load  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0; ena = 1'b0; cfg_load = 1'b0;
    period_in = '0; width_in = '0; burst_in = '0;
    tick(); tick();
    check("rst_pulse", {63'd0, pulse}, 64'd0);
    check("rst_busy",  {63'd0, busy},  64'd0);
    check("rst_done",  {63'd0, done},  64'd0);
    check("rst_cnt",   {48'd0, period_cnt}, 64'd0);
    rst = 1'b1;
    tick();

    // Continuous 10/3: high at k%10<3 -> bits 0,1,2,10,11,12
    load(10, 3, 0);
    ena = 1'b1;
    vec = '0;
    for (int k = 0; k < 20; k++) begin
      tick();
      vec[k] = pulse;
      if (k == 0) check("cont_busy", {63'd0, busy}, 64'd1);
    end
    check("cont_pattern", vec, 64'h01C07);
    check("cont_cnt", {48'd0, period_cnt}, 64'd1);
    ena = 1'b0;
    tick();
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_cnt_held", {48'd0, period_cnt}, 64'd1);

    // Burst 5/2 x4: highs at 0,1,5,6,10,11,15,16; done at k=20
    load(5, 2, 4);
    ena = 1'b1;
    vec = '0;
    for (int k = 0; k < 22; k++) begin
      tick();
      if (k <= 20) vec[k] = pulse;
      if (k == 19) check("burst_done_early", {63'd0, done}, 64'd0);
      if (k == 20) begin
        check("burst_done", {63'd0, done}, 64'd1);
        check("burst_busy", {63'd0, busy}, 64'd0);
        check("burst_cnt",  {48'd0, period_cnt}, 64'd4);
      end
      if (k == 21) begin
        check("burst_done_1cyc", {63'd0, done}, 64'd0);
        check("burst_no_restart", {63'd0, busy}, 64'd0);
      end
    end
    check("burst_pattern", vec, 64'h18C63);
    ena = 1'b0;
    tick();

    // Width 0 then width >= period
    load(8, 0, 0);
    ena = 1'b1;
    vec = '0;
    for (int k = 0; k < 12; k++) begin
      tick();
      vec[k] = pulse;
    end
    check("w0_low", vec, 64'h0);
    check("w0_busy", {63'd0, busy}, 64'd1);
    ena = 1'b0;
    tick();
    load(8, 12, 0);
    ena = 1'b1;
    vec = '0;
    for (int k = 0; k < 12; k++) begin
      tick();
      vec[k] = pulse;
    end
    check("wbig_high", vec, 64'hFFF);
    ena = 1'b0;
    tick();

    // Mid-period reload: 10/3 then 6/1 -> highs at 0,1,2,10,16
    load(10, 3, 0);
    ena = 1'b1;
    vec = '0;
    for (int k = 0; k < 20; k++) begin
      if (k == 5) begin
        period_in = CNT_W'(6);
        width_in  = CNT_W'(1);
        burst_in  = '0;
        cfg_load  = 1'b1;
      end
      tick();
      cfg_load = 1'b0;
      vec[k] = pulse;
    end
    check("reload_pattern", vec, 64'h10407);
    ena = 1'b0;
    tick();

    // Start and cfg_load on the same edge: 4/1 -> highs at 0,4
    period_in = CNT_W'(4);
    width_in  = CNT_W'(1);
    burst_in  = '0;
    cfg_load  = 1'b1;
    ena       = 1'b1;
    vec = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      cfg_load = 1'b0;
      vec[k] = pulse;
    end
    check("start_load_pattern", vec, 64'h11);
    ena = 1'b0;
    tick();

    // Abort at ph=2 then restart
    load(10, 3, 0);
    ena = 1'b1;
    tick();
    tick();
    ena = 1'b0;
    tick();
    check("abort_pulse", {63'd0, pulse}, 64'd0);
    check("abort_done",  {63'd0, done},  64'd0);
    ena = 1'b1;
    tick();
    check("restart_pulse", {63'd0, pulse}, 64'd1);

    // Async reset during high phase, then period=0 blocks start
    tick();
    check("pre_rst_pulse", {63'd0, pulse}, 64'd1);
    rst = 1'b0;
    #1;
    check("async_rst_pulse", {63'd0, pulse}, 64'd0);
    check("async_rst_done",  {63'd0, done},  64'd0);
    ena = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    load(0, 3, 0);
    ena = 1'b1;
    tick();
    tick();
    check("p0_busy",  {63'd0, busy},  64'd0);
    check("p0_pulse", {63'd0, pulse}, 64'd0);
    ena = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
